// File: rtl/conv_encoder_punct_if.sv
// Bit-serial stream bundle for conv_encoder_punct.
// The input side (in_*) carries scrambled data bits into the encoder and the
// output side (out_*) carries coded bits to the interleaver. The encoder uses
// the slave modport; the surrounding logic (or a bench) uses the master modport.
interface conv_encoder_punct_if;
   logic in_valid;
   logic in_bit;
   logic in_last;
   logic in_ready;
   logic out_valid;
   logic out_bit;
   logic out_last;
   logic out_ready;

   modport slave (
      input  in_valid, in_bit, in_last, out_ready,
      output in_ready, out_valid, out_bit, out_last
   );

   modport master (
      output in_valid, in_bit, in_last, out_ready,
      input  in_ready, out_valid, out_bit, out_last
   );
endinterface

// File: rtl/conv_encoder_punct.sv
// conv_encoder_punct
// 802.11a rate-1/2, K=7 convolutional encoder (g0=133o, g1=171o) with
// puncturing to 2/3 or 3/4. One data bit in, up to two coded bits pushed into
// a small output FIFO per accepted bit; the FIFO head drives the serial output.
// Optional feature macro: TAIL_FLUSH_EN -- when defined, six zero tail bits are
// injected after in_last so the trellis returns to the all-zero state and
// out_last tags the final tail-derived coded bit. When undefined, upstream is
// expected to supply the tail and out_last tags the last bit coded from the
// in_last data bit.
module conv_encoder_punct #(
   parameter int BUF_DEPTH = 4
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [1:0]            rate,
   conv_encoder_punct_if.slave   io,
   output logic                  busy
);

   localparam int PW = (BUF_DEPTH <= 2) ? 1 : $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      TAIL  = 2'd2,
      DRAIN = 2'd3
   } state_t;

`ifdef TAIL_FLUSH_EN
   localparam state_t AFTER_LAST = TAIL;
`else
   localparam state_t AFTER_LAST = DRAIN;
`endif

   // Generator g0 = 133o: taps at delays 0,2,3,5,6.
   function automatic logic code_a(input logic b, input logic [5:0] s);
      return b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
   endfunction

   // Generator g1 = 171o: taps at delays 0,1,2,3,6.
   function automatic logic code_b(input logic b, input logic [5:0] s);
      return b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
   endfunction

   // Circular pointer advance; depth need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (int'(p) == BUF_DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   // Frame control state
   state_t          state;
   logic [1:0]      rate_q;
   logic [1:0]      phase;
   logic [5:0]      sreg;
   logic [2:0]      tail_cnt;

   // Output FIFO
   logic [BUF_DEPTH-1:0] mem_bit;
   logic [BUF_DEPTH-1:0] mem_last;
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        wr_ptr_nx1;
   logic [CW-1:0]        occ;

   // Combinational datapath/control
   logic       fifo_nempty;
   logic       free_ok;
   logic       in_ready_c;
   logic       acc;
   logic       tail_go;
   logic       enc_go;
   logic       enc_bit;
   logic [1:0] eff_rate;
   logic       bit_a;
   logic       bit_b;
   logic       keep_a;
   logic       keep_b;
   logic [1:0] phase_nxt;
   logic       frame_end;
   logic [1:0] push_cnt;
   logic       push_bit0;
   logic       push_bit1;
   logic       push_last0;
   logic       push_last1;
   logic       pop;
   logic       pop_last;

   assign fifo_nempty = (occ != '0);
   assign free_ok     = (int'(occ) <= BUF_DEPTH - 2);
   assign in_ready_c  = !Reset && ((state == IDLE) || (state == DATA)) && free_ok;
   assign acc         = io.in_valid && in_ready_c;
   assign tail_go     = (state == TAIL) && free_ok;
   assign enc_go      = acc || tail_go;
   assign enc_bit     = acc ? io.in_bit : 1'b0;
   assign eff_rate    = (state == IDLE) ? rate : rate_q;
   assign bit_a       = code_a(enc_bit, sreg);
   assign bit_b       = code_b(enc_bit, sreg);
   assign pop         = fifo_nempty && io.out_ready;
   assign pop_last    = pop && mem_last[rd_ptr];
   assign wr_ptr_nx1  = ptr_inc(wr_ptr);

`ifdef TAIL_FLUSH_EN
   assign frame_end = tail_go && (tail_cnt == 3'd5);
`else
   assign frame_end = acc && io.in_last;
`endif

   // Puncture pattern selection and next phase for the bit being encoded.
   always_comb begin
      keep_a    = 1'b1;
      keep_b    = 1'b1;
      phase_nxt = 2'd0;
      case (eff_rate)
         2'b01: begin
            keep_b    = (phase == 2'd0);
            phase_nxt = (phase == 2'd1) ? 2'd0 : 2'd1;
         end
         2'b10: begin
            keep_a    = (phase != 2'd2);
            keep_b    = (phase != 2'd1);
            phase_nxt = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
         end
         default: begin
            keep_a    = 1'b1;
            keep_b    = 1'b1;
            phase_nxt = 2'd0;
         end
      endcase
   end

   // Kept bits are packed A-then-B; the frame-end tag goes on whichever is last.
   always_comb begin
      push_cnt   = 2'd0;
      push_bit0  = 1'b0;
      push_bit1  = 1'b0;
      push_last0 = 1'b0;
      push_last1 = 1'b0;
      if (enc_go) begin
         if (keep_a && keep_b) begin
            push_cnt   = 2'd2;
            push_bit0  = bit_a;
            push_bit1  = bit_b;
            push_last1 = frame_end;
         end else begin
            push_cnt   = 2'd1;
            push_bit0  = keep_a ? bit_a : bit_b;
            push_last0 = frame_end;
         end
      end
   end

   // FIFO storage: data only, no reset needed since occupancy gates the output.
   always_ff @(posedge Clk) begin
      if (push_cnt != 2'd0) begin
         mem_bit[wr_ptr]  <= push_bit0;
         mem_last[wr_ptr] <= push_last0;
      end
      if (push_cnt == 2'd2) begin
         mem_bit[wr_ptr_nx1]  <= push_bit1;
         mem_last[wr_ptr_nx1] <= push_last1;
      end
   end

   // FIFO pointers and occupancy; push and pop may coincide.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         if (push_cnt == 2'd2)
            wr_ptr <= ptr_inc(wr_ptr_nx1);
         else if (push_cnt == 2'd1)
            wr_ptr <= wr_ptr_nx1;
         occ <= occ + CW'(push_cnt) - CW'(pop);
      end
   end

   // Frame FSM with encoder state, puncture phase, tail count and busy flag.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         rate_q   <= 2'b00;
         phase    <= 2'd0;
         sreg     <= 6'd0;
         tail_cnt <= 3'd0;
         busy     <= 1'b0;
      end else begin
         if (enc_go) begin
            sreg  <= {sreg[4:0], enc_bit};
            phase <= phase_nxt;
         end
         case (state)
            IDLE: begin
               if (acc) begin
                  rate_q <= rate;
                  busy   <= 1'b1;
                  state  <= io.in_last ? AFTER_LAST : DATA;
               end
            end
            DATA: begin
               if (acc && io.in_last)
                  state <= AFTER_LAST;
            end
            TAIL: begin
               if (tail_go) begin
                  tail_cnt <= tail_cnt + 3'd1;
                  if (tail_cnt == 3'd5)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop_last) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  sreg     <= 6'd0;
                  phase    <= 2'd0;
                  tail_cnt <= 3'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign io.in_ready  = in_ready_c;
   assign io.out_valid = fifo_nempty;
   assign io.out_bit   = fifo_nempty & mem_bit[rd_ptr];
   assign io.out_last  = fifo_nempty & mem_last[rd_ptr];

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: directed vectors plus randomized frames
// checked against a convolution/puncture-matrix reference model.
module tb_conv_encoder_punct;

   localparam int BUF_DEPTH = 4;

   logic       Clk;
   logic       Reset;
   logic [1:0] rate;
   logic       busy;

   conv_encoder_punct_if ifc ();

   conv_encoder_punct #(.BUF_DEPTH(BUF_DEPTH)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .rate  (rate),
      .io    (ifc.slave),
      .busy  (busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_chk  = 0;
   int n_fail = 0;

   bit stim_q[$];
   bit exp_q[$];
   bit got_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic bit tap(input bit x[$], input int k, input int d);
      return (k - d >= 0) ? x[k - d] : 1'b0;
   endfunction

   // Reference: mother code as polynomial convolution, then puncture matrix.
   function automatic void build_expected(input logic [1:0] r);
      bit x[$];
      int pa[3];
      int pb[3];
      int per;
      bit a, b;
      x = stim_q;
`ifdef TAIL_FLUSH_EN
      for (int i = 0; i < 6; i++) x.push_back(1'b0);
`endif
      case (r)
         2'b01:   begin per = 2; pa = '{1, 1, 0}; pb = '{1, 0, 0}; end
         2'b10:   begin per = 3; pa = '{1, 1, 0}; pb = '{1, 0, 1}; end
         default: begin per = 1; pa = '{1, 0, 0}; pb = '{1, 0, 0}; end
      endcase
      exp_q.delete();
      for (int k = 0; k < x.size(); k++) begin
         a = tap(x, k, 0) ^ tap(x, k, 2) ^ tap(x, k, 3) ^ tap(x, k, 5) ^ tap(x, k, 6);
         b = tap(x, k, 0) ^ tap(x, k, 1) ^ tap(x, k, 2) ^ tap(x, k, 3) ^ tap(x, k, 6);
         if (pa[k % per] != 0) exp_q.push_back(a);
         if (pb[k % per] != 0) exp_q.push_back(b);
      end
   endfunction

   function automatic logic [31:0] pack_got(input int n);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n && i < got_q.size(); i++) v = {v[30:0], got_q[i]};
      return v;
   endfunction

   // mode 0: out_ready=1; 1: random valid/ready; 2: out_ready=0 for 10 cycles;
   // 3: like 0 but rate input changes after first accept.
   task automatic run_frame(input string tag, input logic [1:0] r, input int mode);
      int  idx, got, cyc, acc10;
      bit  stall, hold_b, hold_l, lat_pend;
      build_expected(r);
      got_q.delete();
      idx = 0; got = 0; cyc = 0; acc10 = 0;
      stall = 0; hold_b = 0; hold_l = 0; lat_pend = 0;
      while (got < exp_q.size() && cyc < 3000) begin
         @(negedge Clk);
         rate = (mode == 3 && idx > 0) ? ~r : r;
         if (idx < stim_q.size()) begin
            ifc.in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            ifc.in_bit   = stim_q[idx];
            ifc.in_last  = (idx == stim_q.size() - 1);
         end else begin
            ifc.in_valid = 1'b0;
            ifc.in_bit   = 1'b0;
            ifc.in_last  = 1'b0;
         end
         if (mode == 1)      ifc.out_ready = ($urandom_range(0, 2) != 0);
         else if (mode == 2) ifc.out_ready = (cyc >= 10);
         else                ifc.out_ready = 1'b1;
         #1;
         if (lat_pend) begin
            chk({tag, " latency out_valid"}, ifc.out_valid, 1);
            chk({tag, " busy in frame"}, busy, 1);
            lat_pend = 0;
         end
         if (stall) begin
            chk({tag, " hold valid"}, ifc.out_valid, 1);
            chk({tag, " hold bit"}, ifc.out_bit, hold_b);
            chk({tag, " hold last"}, ifc.out_last, hold_l);
         end
         if (ifc.in_valid && ifc.in_ready) begin
            if (idx == 0) lat_pend = 1;
            idx++;
            if (mode == 2 && cyc < 10) acc10++;
         end
         if (ifc.out_valid && ifc.out_ready) begin
            chk({tag, " bit"}, ifc.out_bit, exp_q[got]);
            chk({tag, " last"}, ifc.out_last, (got == exp_q.size() - 1));
            got_q.push_back(ifc.out_bit);
            got++;
         end
         stall  = ifc.out_valid && !ifc.out_ready;
         hold_b = ifc.out_bit;
         hold_l = ifc.out_last;
         cyc++;
      end
      chk({tag, " count/timeout"}, got, exp_q.size());
      @(negedge Clk);
      ifc.in_valid  = 1'b0;
      ifc.in_last   = 1'b0;
      ifc.out_ready = 1'b1;
      #1;
      chk({tag, " busy after"}, busy, 0);
      chk({tag, " empty after"}, ifc.out_valid, 0);
      chk({tag, " in_ready after"}, ifc.in_ready, 1);
      if (mode == 2) chk({tag, " accepts under stall"}, acc10, BUF_DEPTH / 2);
   endtask

   task automatic load_impulse();
      stim_q.delete();
      stim_q.push_back(1'b1);
`ifndef TAIL_FLUSH_EN
      for (int i = 0; i < 6; i++) stim_q.push_back(1'b0);
`endif
   endtask

   initial begin
      Reset = 1'b1;
      rate  = 2'b00;
      ifc.in_valid  = 1'b0;
      ifc.in_bit    = 1'b0;
      ifc.in_last   = 1'b0;
      ifc.out_ready = 1'b0;

      // Reset behaviour
      repeat (2) @(negedge Clk);
      #1;
      chk("in_ready during reset", ifc.in_ready, 0);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk("reset out_valid", ifc.out_valid, 0);
      chk("reset out_bit", ifc.out_bit, 0);
      chk("reset out_last", ifc.out_last, 0);
      chk("reset busy", busy, 0);
      chk("in_ready after reset", ifc.in_ready, 1);

      // Impulse at rate 1/2
      load_impulse();
      run_frame("impulse", 2'b00, 0);
      chk("impulse size", got_q.size(), 14);
      chk("impulse vector", pack_got(14), 32'(14'b11_01_11_11_00_10_11));

      // Rate 2/3, bits 1,0,0,0
      stim_q = '{1'b1, 1'b0, 1'b0, 1'b0};
      run_frame("r23", 2'b01, 0);
      chk("r23 prefix", pack_got(6), 32'(6'b110111));

      // Rate 3/4, six ones
      stim_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      run_frame("r34", 2'b10, 0);
`ifdef TAIL_FLUSH_EN
      chk("r34 size", got_q.size(), 16);
`else
      chk("r34 size", got_q.size(), 8);
`endif

      // Backpressure at rate 1/2
      stim_q.delete();
      for (int i = 0; i < 20; i++) stim_q.push_back(1'($urandom));
      run_frame("bp", 2'b00, 2);

      // Rate input changed mid-frame is ignored
      stim_q.delete();
      for (int i = 0; i < 12; i++) stim_q.push_back(1'($urandom));
      run_frame("ratechg", 2'b10, 3);

      // Reset in the middle of a frame
      @(negedge Clk);
      rate = 2'b00;
      ifc.in_valid  = 1'b1;
      ifc.in_bit    = 1'b1;
      ifc.in_last   = 1'b0;
      ifc.out_ready = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      ifc.in_valid = 1'b0;
      #1;
      chk("mid-reset in_ready", ifc.in_ready, 0);
      @(negedge Clk);
      Reset = 1'b0;
      ifc.out_ready = 1'b1;
      #1;
      chk("mid-reset out_valid", ifc.out_valid, 0);
      chk("mid-reset busy", busy, 0);
      chk("mid-reset out_last", ifc.out_last, 0);
      load_impulse();
      run_frame("post-reset impulse", 2'b00, 0);
      chk("post-reset vector", pack_got(14), 32'(14'b11_01_11_11_00_10_11));

      // Randomized frames, all rate codes, random handshakes
      for (int f = 0; f < 8; f++) begin
         stim_q.delete();
         for (int i = 0; i < $urandom_range(1, 30); i++) stim_q.push_back(1'($urandom));
         run_frame($sformatf("rand%0d", f), 2'($urandom_range(0, 3)), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
